pc_unit: RTL
============

# pc_unit

Program-counter and next-address stage of the single-cycle MIPS datapath, directly upstream of the instruction memory. Holds the current word-indexed PC, drives it as the instruction memory address, and computes the next PC from sequential, branch, jump and jump-register requests issued by control. Adds a boot/run/halt state machine and a retired-instruction counter used by the testbench and debug display.

## Interface
- ADDR_W, 8: PC width in instruction words; matches the instruction memory address width.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 32: retired-instruction counter width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  hold PC and counter this cycle.
- halt_req  in  1  current instruction is the halt instruction.
- branch_taken  in  1  conditional branch resolved taken.
- branch_off  in  16  signed word offset, sign-extended imm16.
- jump  in  1  J/JAL.
- jump_target  in  26  instr[25:0]; low ADDR_W bits used.
- jr  in  1  JR.
- jr_target  in  32  register value; low ADDR_W bits used as word index.
- pc  out  ADDR_W  current PC, to the instruction memory addr.
- pc_plus1  out  ADDR_W  pc+1 mod 2^ADDR_W, JAL link value.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- retired  out  CNT_W  instructions completed since reset.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; lasts exactly one cycle so the instruction memory image reload completes; PC held at RESET_PC; then RUN.
- RUN: the instruction at pc executes this cycle. Next-PC priority: stall > halt_req > jr > jump > branch_taken > sequential.
  - stall: pc, retired and state unchanged.
  - halt_req: pc unchanged, retired unchanged, state -> HALT.
  - jr: pc <= jr_target[ADDR_W-1:0].
  - jump: pc <= jump_target[ADDR_W-1:0].
  - branch_taken: pc <= pc + 1 + branch_off, truncated to ADDR_W (two's complement, mod 2^ADDR_W).
  - otherwise: pc <= pc + 1.
  - Every non-stall, non-halt RUN cycle: retired += 1, saturating at 2^CNT_W-1.
- HALT: absorbing; pc, retired frozen; all request inputs ignored; only reset exits.
- Multiple requests asserted together: the highest priority wins, the others are ignored without error.
- Wrap-around: pc = 2^ADDR_W-1 with sequential advance -> 0; no flag.

## Timing
- Reset (rst=0 at a rising edge): pc=RESET_PC, retired=0, state=BOOT, running=0, halted=0, pc_plus1=RESET_PC+1.
- Reset asserted mid-RUN or in HALT overrides everything at that edge.
- pc, state and retired are registered; running, halted and pc_plus1 are combinational from the registers.
- Request inputs are sampled at the edge ending the cycle; the new pc is visible right after that edge, so the instruction memory output is valid in the same cycle (zero-cycle fetch latency).
- Request inputs are ignored in BOOT.

## Structure
- Shared package `mips_pkg`: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the default ADDR_W; the instruction memory uses the same ADDR_W constant.
- One sub-module, `next_pc_sel`: purely combinational priority mux and adder; the FSM, pc register and counter stay in pc_unit.

## Test plan
- Reset then release, no requests: cycle 0 BOOT pc=0; then pc=0,1,2,3 on consecutive edges; retired=3 after the third RUN edge.
- From pc=10, branch_taken with branch_off=-4 -> pc=7; branch_off=+5 from pc=7 -> pc=13.
- At pc=20, jump=1 with jump_target=26'h3FF_FF42 and jr=1 with jr_target=32'h0000_0033 together -> pc=0x33 (jr wins); pc_plus1=0x34.
- pc=255 with sequential advance -> pc=0; stall=1 for 3 cycles at pc=5 -> pc stays 5, retired unchanged.
- halt_req at pc=9 -> halted=1, pc stays 9 for 10 further cycles despite jump/branch activity; retired equals its value before halt.
- rst=0 mid-RUN at pc=40 -> next edge pc=0, retired=0, BOOT; one cycle later running=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: pc_unit state encoding and the
// instruction-memory word-address width used by both pc_unit and imem.
package mips_pkg;

  localparam int MIPS_ADDR_W = 8;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-address selection for the program counter: priority mux over
// jump-register, jump, taken branch and sequential advance. Purely
// combinational; stall/halt/boot gating lives in pc_unit.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [15:0]       branch_off,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] next_pc
);

  logic [31:0]       off_sext;
  logic [ADDR_W-1:0] branch_pc;
  logic              unused_bits;

  // Offset is sign-extended to 32 bits first so the truncated add is
  // correct modulo 2^ADDR_W for any ADDR_W up to the jump field width.
  assign off_sext  = {{16{branch_off[15]}}, branch_off};
  assign pc_plus1  = pc + ADDR_W'(1);
  assign branch_pc = pc_plus1 + off_sext[ADDR_W-1:0];

  // High address bits beyond the instruction memory are intentionally dropped.
  assign unused_bits = ^{jump_target[25:ADDR_W], jr_target[31:ADDR_W],
                         off_sext[31:ADDR_W]};

  // Priority: jr over jump over taken branch over sequential.
  always_comb begin
    next_pc = pc_plus1;
    if (jr) begin
      next_pc = jr_target[ADDR_W-1:0];
    end else if (jump) begin
      next_pc = jump_target[ADDR_W-1:0];
    end else if (branch_taken) begin
      next_pc = branch_pc;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter stage: holds the word-indexed PC feeding instruction
// memory, runs the BOOT/RUN/HALT sequencer and counts retired instructions.
module pc_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic [15:0]       branch_off,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [ADDR_W-1:0] next_pc;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc_plus1     (pc_plus1),
    .next_pc      (next_pc)
  );

  // Sequencer and next-state for pc/retired; everything holds unless a RUN
  // cycle actually completes an instruction.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (halt_req) begin
          state_d = HALT;
        end else begin
          pc_d      = next_pc;
          retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BOOT;
      pc_q      <= ADDR_W'(RESET_PC);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign running = (state_q == RUN);
  assign halted  = (state_q == HALT);

endmodule
